// File: rtl/keccak_pkg.sv
// keccak_pkg: constants, state encoding and helper functions that the
// Keccak-f[1600] round-constant generator and its LFSR share.
//   KECCAK_ROUNDS      rounds in a full Keccak-f[1600] permutation
//   LANE_W             width of one state lane
//   RC_BITS_PER_ROUND  rc(t) bits consumed per round constant
//   RC_LFSR_SEED/TAPS  rc(t) LFSR seed and feedback mask
package keccak_pkg;

  localparam int KECCAK_ROUNDS     = 24;
  localparam int LANE_W            = 64;
  localparam int RC_BITS_PER_ROUND = 7;

  localparam logic [7:0] RC_LFSR_SEED = 8'h01;
  localparam logic [7:0] RC_LFSR_TAPS = 8'h71;

  typedef enum logic [1:0] {
    IDLE,
    GEN,
    OFFER
  } rc_state_t;

  // One rc(t) step: shift left and fold the shifted-out bit back through
  // the taps (x^8 = x^6 + x^5 + x^4 + 1).
  function automatic logic [7:0] rc_lfsr_next(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? RC_LFSR_TAPS : 8'h00);
  endfunction

  // Lane bit written by step j of a round: 2^j - 1 (0, 1, 3, 7, 15, 31, 63).
  function automatic logic [5:0] rc_bit_pos(input logic [2:0] j);
    return 6'((7'd1 << j) - 7'd1);
  endfunction

endpackage

// File: rtl/rc_lfsr.sv
// rc_lfsr: 8-bit rc(t) LFSR.
//   clk, rst_n  clock, asynchronous active-low reset (resets to the seed)
//   load_i      reload the seed (wins over step_i)
//   step_i      advance one step
//   bit_o       current output bit rc(t) = R[0]
module rc_lfsr
  import keccak_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic step_i,
  output logic bit_o
);

  logic [7:0] r_q;
  logic [7:0] r_d;

  always_comb begin
    r_d = r_q;
    if (load_i)      r_d = RC_LFSR_SEED;
    else if (step_i) r_d = rc_lfsr_next(r_q);
  end

  // NOTE: flops take non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= RC_LFSR_SEED;
    else        r_q <= r_d;
  end

  assign bit_o = r_q[0];

endmodule

// File: rtl/keccak_rc_gen.sv
// keccak_rc_gen: sequential Keccak-f[1600] round-constant generator.
// Builds RC[r] one rc(t) bit per cycle (7 cycles per round) and offers it
// with its round index over a valid/ready handshake to the Iota step.
//   clk, rst_n  clock, asynchronous active-low reset
//   start       begin a new sequence (sampled only in IDLE)
//   abort       synchronous return to IDLE, overrides start and handshake
//   rc_ready    consumer accepts the offered constant
//   rc_valid    rc_lane/rc_round hold a valid constant
//   rc_lane     RC[r], bit k is lane bit k
//   rc_round    round index r of the offered constant
//   busy        high whenever not IDLE
//   done        one-cycle pulse after the last constant is accepted
module keccak_rc_gen
  import keccak_pkg::*;
#(
  parameter int NUM_ROUNDS = KECCAK_ROUNDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              rc_ready,
  output logic              rc_valid,
  output logic [LANE_W-1:0] rc_lane,
  output logic [4:0]        rc_round,
  output logic              busy,
  output logic              done
);

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS - 1);
  localparam logic [2:0] LAST_STEP  = 3'(RC_BITS_PER_ROUND - 1);

  rc_state_t         state_q, state_d;
  logic [4:0]        round_q, round_d;
  logic [2:0]        step_q,  step_d;
  logic [LANE_W-1:0] lane_q,  lane_d;
  logic              done_q,  done_d;

  logic lfsr_load;
  logic lfsr_step;
  logic lfsr_bit;

  rc_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (lfsr_load),
    .step_i (lfsr_step),
    .bit_o  (lfsr_bit)
  );

  always_comb begin
    // NOTE: every signal gets its hold/idle value first, so no path through
    // the case below can leave one unassigned and infer a latch.
    state_d   = state_q;
    round_d   = round_q;
    step_d    = step_q;
    lane_d    = lane_q;
    done_d    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    if (abort) begin
      // Nothing else moves: an offered constant is not transferred and the
      // LFSR is left alone; the next start reseeds it anyway.
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            lfsr_load = 1'b1;
            round_d   = '0;
            step_d    = '0;
            lane_d    = '0;
            state_d   = GEN;
          end
        end
        GEN: begin
          lane_d[rc_bit_pos(step_q)] = lfsr_bit;
          lfsr_step = 1'b1;
          if (step_q == LAST_STEP) state_d = OFFER;
          else                     step_d  = step_q + 3'd1;
        end
        OFFER: begin
          if (rc_ready) begin
            if (round_q == LAST_ROUND) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              round_d = round_q + 5'd1;
              lane_d  = '0;
              step_d  = '0;
              state_d = GEN;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      step_q  <= '0;
      lane_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      step_q  <= step_d;
      lane_q  <= lane_d;
      done_q  <= done_d;
    end
  end

  // Outputs decode registers only; no input reaches them combinationally.
  assign rc_valid = (state_q == OFFER);
  assign busy     = (state_q != IDLE);
  assign rc_lane  = lane_q;
  assign rc_round = round_q;
  assign done     = done_q;

endmodule

// File: tb/tb_keccak_rc_gen.sv
// tb_keccak_rc_gen: self-checking bench for keccak_rc_gen.
// Expected constants come from the polynomial definition of rc(t):
// rc(t) is the constant term of x^t mod (x^8 + x^6 + x^5 + x^4 + 1), and
// RC[r] has rc(7r+j) at lane bit 2^j - 1. A few FIPS-202 values are also
// checked as fixed anchors. A second instance with NUM_ROUNDS = 12 covers
// short sequences; its last constant is RC[11] = 64'h000000008000000A.
module tb_keccak_rc_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        rc_ready;

  logic        v24, b24, d24;
  logic [63:0] l24;
  logic [4:0]  r24;
  logic        v12, b12, d12;
  logic [63:0] l12;
  logic [4:0]  r12;

  int checks   = 0;
  int failures = 0;
  bit sel12    = 1'b0;

  keccak_rc_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .rc_ready (rc_ready),
    .rc_valid (v24),
    .rc_lane  (l24),
    .rc_round (r24),
    .busy     (b24),
    .done     (d24)
  );

  keccak_rc_gen #(.NUM_ROUNDS(12)) dut12 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .rc_ready (rc_ready),
    .rc_valid (v12),
    .rc_lane  (l12),
    .rc_round (r12),
    .busy     (b12),
    .done     (d12)
  );

  // Outputs of whichever instance the current sequence test observes.
  logic        o_valid, o_busy, o_done;
  logic [63:0] o_lane;
  logic [4:0]  o_round;
  assign o_valid = sel12 ? v12 : v24;
  assign o_busy  = sel12 ? b12 : b24;
  assign o_done  = sel12 ? d12 : d24;
  assign o_lane  = sel12 ? l12 : l24;
  assign o_round = sel12 ? r12 : r24;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit rc_bit(input int t);
    bit [8:0] p;
    p = 9'h001;
    for (int i = 0; i < (t % 255); i++) begin
      p = p << 1;
      if (p[8]) p = p ^ 9'h171;
    end
    return p[0];
  endfunction

  function automatic logic [63:0] rc_const(input int r);
    logic [63:0] c;
    c = '0;
    for (int j = 0; j < 7; j++) c[(1 << j) - 1] = rc_bit(j + 7 * r);
    return c;
  endfunction

  // Runs one sequence on the selected instance from the current sample
  // point (#1 after an edge). Optional random 0..10-cycle stalls and random
  // start pulses while busy. Returns at the sample where done is expected.
  task automatic run_seq(input int nrounds, input bit stalls, input bit noise, input bit issue_start);
    int          idx;
    int          stall_left;
    int          budget;
    bit          pend;
    bit          held;
    bit          fin;
    logic [63:0] hl;
    logic [4:0]  hr;
    idx = 0; stall_left = 0; pend = 0; held = 0; fin = 0;
    hl = '0; hr = '0;
    budget = nrounds * 20 + 20;
    if (issue_start) start = 1'b1;
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (pend) begin
        pend = 1'b0;
        held = 1'b0;
        idx++;
        if (idx == nrounds) begin
          check("seq_done", 64'(o_done), 64'd1);
          check("seq_idle", 64'(o_busy), 64'd0);
          fin = 1'b1;
        end
      end
      if (!fin) begin
        check("seq_no_done", 64'(o_done), 64'd0);
        if (o_valid) begin
          if (held) begin
            check("stall_lane", o_lane, hl);
            check("stall_round", 64'(o_round), 64'(hr));
          end else begin
            check("seq_round", 64'(o_round), 64'(idx));
            check("seq_lane", o_lane, rc_const(idx));
            hl = o_lane;
            hr = o_round;
            stall_left = stalls ? int'($urandom_range(0, 10)) : 0;
          end
          if (stall_left == 0) begin
            rc_ready = 1'b1;
            pend     = 1'b1;
            held     = 1'b0;
          end else begin
            rc_ready = 1'b0;
            stall_left--;
            held     = 1'b1;
          end
        end else begin
          if (held) check("stall_valid_held", 64'(o_valid), 64'd1);
          held     = 1'b0;
          rc_ready = 1'($urandom_range(0, 1));
        end
        if (noise && o_busy) start = 1'($urandom_range(0, 1));
      end
    end
    start = 1'b0;
    if (!fin) check("seq_timeout", 64'(fin), 64'd1);
  endtask

  initial begin
    bit   exp_valid;
    bit   found;
    int   r;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rc_ready = 1'b0;
    #12;
    check("rst_valid", 64'(v24), 64'd0);
    check("rst_lane",  l24, 64'd0);
    check("rst_round", 64'(r24), 64'd0);
    check("rst_busy",  64'(b24), 64'd0);
    check("rst_done",  64'(d24), 64'd0);
    #3 rst_n = 1'b1;

    // Cycle-exact full sequence, rc_ready tied high. Start sampled at E0.
    @(posedge clk); #1;
    rc_ready = 1'b1;
    start    = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      exp_valid = (n >= 7) && (n <= 191) && ((n % 8) == 7);
      check("t1_valid", 64'(v24), 64'(exp_valid));
      check("t1_done",  64'(d24), 64'(n == 192));
      check("t1_busy",  64'(b24), 64'(n < 192));
      if (exp_valid && v24) begin
        r = (n - 7) / 8;
        check("t1_round", 64'(r24), 64'(r));
        check("t1_lane",  l24, rc_const(r));
        if (r == 0)  check("t1_rc0",  l24, 64'h0000000000000001);
        if (r == 1)  check("t1_rc1",  l24, 64'h0000000000008082);
        if (r == 23) check("t1_rc23", l24, 64'h8000000080008008);
      end
    end

    // Random stalls and start noise, then a start in the done cycle.
    run_seq(24, 1'b1, 1'b1, 1'b1);
    run_seq(24, 1'b0, 1'b0, 1'b1);

    // Abort while round 5 is offered with rc_ready high.
    @(posedge clk); #1;
    rc_ready = 1'b1;
    start    = 1'b1;
    found    = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (v24 && r24 == 5'd5) found = 1'b1;
    end
    check("ab_reached", 64'(found), 64'd1);
    check("ab_lane5", l24, rc_const(5));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("ab_valid", 64'(v24), 64'd0);
    check("ab_busy",  64'(b24), 64'd0);
    check("ab_done",  64'(d24), 64'd0);
    @(posedge clk); #1;
    check("ab_done2", 64'(d24), 64'd0);
    check("ab_idle2", 64'(b24), 64'd0);
    run_seq(24, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset in the middle of round 10's GEN phase.
    @(posedge clk); #1;
    rc_ready = 1'b1;
    start    = 1'b1;
    found    = 1'b0;
    for (int n = 0; n < 150 && !found; n++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (b24 && !v24 && r24 == 5'd10) found = 1'b1;
    end
    check("rst10_reached", 64'(found), 64'd1);
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rst10_valid", 64'(v24), 64'd0);
    check("rst10_lane",  l24, 64'd0);
    check("rst10_round", 64'(r24), 64'd0);
    check("rst10_busy",  64'(b24), 64'd0);
    check("rst10_done",  64'(d24), 64'd0);
    rst_n = 1'b1;

    // Short sequence on the NUM_ROUNDS = 12 instance.
    @(posedge clk); #1;
    sel12 = 1'b1;
    run_seq(12, 1'b1, 1'b1, 1'b1);
    check("n12_last_lane", l12, rc_const(11));
    check("n12_last_round", 64'(r12), 64'd11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
